// File: rtl/bcd_conv_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle binary-to-BCD converter.
// It handles the start/done handshake, clamps operands above the overflow limit, and aborts a stalled conversion.
module bcd_conv_arbiter #(
  parameter int unsigned      WIDTH          = 16,
  parameter int unsigned      MAX_VALUE      = 9999,
  parameter logic [WIDTH-1:0] OVF_CODE       = 16'hE000,
  parameter int unsigned      TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] bin0_i,
  input  logic [WIDTH-1:0] bin1_i,
  output logic [1:0]       done_o,
  output logic [WIDTH-1:0] bcd_o,
  output logic             ovf_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             conv_start_o,
  output logic [WIDTH-1:0] conv_bin_o,
  input  logic             conv_done_i,
  input  logic [WIDTH-1:0] conv_bcd_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       done_q, done_d;
  logic [WIDTH-1:0] bcd_q, bcd_d;
  logic [WIDTH-1:0] conv_bin_q, conv_bin_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;

  logic             winner;
  logic [WIDTH-1:0] winner_bin;
  logic             winner_ovf;
  logic             timeout;

  // With both requests pending, the requester that was not served last goes next.
  assign winner     = (req_i == 2'b11) ? ~last_grant_q : req_i[1];
  assign winner_bin = winner ? bin1_i : bin0_i;
  assign winner_ovf = winner_bin > WIDTH'(MAX_VALUE);
  assign timeout    = (cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_i != 2'b00) state_d = winner_ovf ? S_RESP : S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (conv_done_i || timeout) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    conv_bin_d   = conv_bin_q;
    bcd_d        = bcd_q;
    done_d       = 2'b00;
    ovf_d        = 1'b0;
    err_d        = 1'b0;
    start_d      = 1'b0;
    busy_d       = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (req_i != 2'b00) begin
          grant_d      = winner;
          last_grant_d = winner;
          conv_bin_d   = winner_bin;
          if (winner_ovf) begin
            done_d = winner ? 2'b10 : 2'b01;
            bcd_d  = OVF_CODE;
            ovf_d  = 1'b1;
          end else begin
            start_d = 1'b1;
          end
        end
      end
      S_START: cnt_d = '0;
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A completion arriving on the timeout cycle still counts as success.
        if (conv_done_i) begin
          done_d = grant_q ? 2'b10 : 2'b01;
          bcd_d  = conv_bcd_i;
        end else if (timeout) begin
          done_d = grant_q ? 2'b10 : 2'b01;
          bcd_d  = OVF_CODE;
          err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      conv_bin_q   <= '0;
      bcd_q        <= '0;
      done_q       <= 2'b00;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      conv_bin_q   <= conv_bin_d;
      bcd_q        <= bcd_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
    end
  end

  assign done_o       = done_q;
  assign bcd_o        = bcd_q;
  assign ovf_o        = ovf_q;
  assign err_o        = err_q;
  assign busy_o       = busy_q;
  assign conv_start_o = start_q;
  assign conv_bin_o   = conv_bin_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Randomised and directed bench for bcd_conv_arbiter, checked against a transaction-level
// model of arbitration order, decimal conversion, overflow clamping and timeout.
module tb_bcd_conv_arbiter;

  localparam int MAXV = 9999;
  localparam int TMO  = 64;
  localparam logic [15:0] OVF = 16'hE000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_i = 2'b00;
  logic [15:0] bin0_i = '0;
  logic [15:0] bin1_i = '0;
  logic [1:0]  done_o;
  logic [15:0] bcd_o;
  logic        ovf_o;
  logic        err_o;
  logic        busy_o;
  logic        conv_start_o;
  logic [15:0] conv_bin_o;
  logic        conv_done_i = 1'b0;
  logic [15:0] conv_bcd_i = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_txn   = 0;
  logic m_last = 1'b1;

  bcd_conv_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req_i        (req_i),
    .bin0_i       (bin0_i),
    .bin1_i       (bin1_i),
    .done_o       (done_o),
    .bcd_o        (bcd_o),
    .ovf_o        (ovf_o),
    .err_o        (err_o),
    .busy_o       (busy_o),
    .conv_start_o (conv_start_o),
    .conv_bin_o   (conv_bin_o),
    .conv_done_i  (conv_done_i),
    .conv_bcd_i   (conv_bcd_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int r;
    r = ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    return r[15:0];
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_bcd"}, bcd_o, 0);
    chk({tag, "_flags"}, {ovf_o, err_o, busy_o, conv_start_o}, 0);
    chk({tag, "_convbin"}, conv_bin_o, 0);
  endtask

  // delay: WAIT cycle (1-based) in which the converter replies; -1 = never replies.
  task automatic do_txn(input logic [1:0] req, input logic [15:0] b0, input logic [15:0] b1,
                        input int delay, input bit hold, input bit drop);
    logic        w;
    logic [15:0] op;
    logic [1:0]  exp_done;
    logic [15:0] exp_bcd;
    logic        exp_ovf, exp_err;
    bit          replied;
    int          k;
    w        = (req == 2'b11) ? ~m_last : req[1];
    m_last   = w;
    op       = w ? b1 : b0;
    exp_done = w ? 2'b10 : 2'b01;
    replied  = 1'b0;
    chk("idle_busy", busy_o, 0);
    req_i  = req;
    bin0_i = b0;
    bin1_i = b1;
    @(posedge clk); #1;
    bin0_i = 16'($urandom);
    bin1_i = 16'($urandom);
    if (drop) req_i = 2'b00;
    if (int'(op) > MAXV) begin
      chk("ovf_nostart", conv_start_o, 0);
    end else begin
      chk("start", {conv_start_o, done_o, busy_o}, 4'b1001);
      chk("conv_bin", conv_bin_o, op);
      k = 0;
      while (!replied && k < TMO) begin
        @(posedge clk); #1;
        k++;
        chk("wait", {conv_start_o, done_o, busy_o}, 4'b0001);
        chk("conv_bin_hold", conv_bin_o, op);
        if (k == delay) begin
          conv_done_i = 1'b1;
          conv_bcd_i  = to_bcd(int'(op));
          replied     = 1'b1;
        end
      end
      @(posedge clk); #1;
      conv_done_i = 1'b0;
      conv_bcd_i  = 16'($urandom);
    end
    if (int'(op) > MAXV) begin
      exp_bcd = OVF; exp_ovf = 1'b1; exp_err = 1'b0;
    end else if (replied) begin
      exp_bcd = to_bcd(int'(op)); exp_ovf = 1'b0; exp_err = 1'b0;
    end else begin
      exp_bcd = OVF; exp_ovf = 1'b0; exp_err = 1'b1;
    end
    chk("done", done_o, exp_done);
    chk("bcd", bcd_o, exp_bcd);
    chk("ovf_err", {ovf_o, err_o}, {exp_ovf, exp_err});
    chk("resp_busy", busy_o, 1);
    n_txn++;
    $display("[TB] txn %0d req=%b op=%0d grant=%0d bcd=%h ovf=%0b err=%0b", n_txn, req, op, w, bcd_o, ovf_o, err_o);
    req_i = hold ? req : 2'b00;
    @(posedge clk); #1;
    chk("post_done", done_o, 0);
    chk("post_flags", {ovf_o, err_o, busy_o}, 0);
    chk("bcd_hold", bcd_o, exp_bcd);
  endtask

  function automatic logic [15:0] rand_op();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 16'd9999;
    if (r == 1) return 16'd10000;
    if (r == 2) return 16'($urandom);
    return 16'($urandom_range(0, 9999));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    do_txn(2'b01, 16'd1234, 16'd0, 5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) do_txn(2'b11, 16'd7, 16'd42, 2, (i < 3), 1'b0);
    do_txn(2'b10, 16'd5, 16'd10000, 3, 1'b0, 1'b0);
    do_txn(2'b01, 16'd9999, 16'd0, 3, 1'b0, 1'b0);
    do_txn(2'b01, 16'd321, 16'd0, -1, 1'b0, 1'b0);
    do_txn(2'b10, 16'd0, 16'd808, 4, 1'b0, 1'b0);
    do_txn(2'b01, 16'd77, 16'd0, TMO, 1'b0, 1'b1);

    // Reset in the middle of a conversion, then a stray completion while idle.
    req_i  = 2'b01;
    bin0_i = 16'd55;
    @(posedge clk); #1;
    req_i = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk); #1;
    chk("reset_nodone", done_o, 0);
    reset  = 1'b0;
    m_last = 1'b1;
    conv_done_i = 1'b1;
    conv_bcd_i  = 16'h1234;
    @(posedge clk); #1;
    conv_done_i = 1'b0;
    @(posedge clk); #1;
    chk("stray_done", {done_o, busy_o, conv_start_o}, 0);
    chk("stray_bcd", bcd_o, 0);
    do_txn(2'b11, 16'd100, 16'd200, 3, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(0, 9);
      if (d == 0)      d = -1;
      else if (d == 1) d = TMO;
      else             d = $urandom_range(1, 6);
      do_txn(2'($urandom_range(1, 3)), rand_op(), rand_op(), d,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
